// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the encoder-driven audio parameter menu.
// Parameter indices name the conventional slot of each control in the menu.
package audio_ctrl_pkg;

    typedef enum logic [1:0] {
        PRESS_IDLE = 2'd0,
        PRESS_HELD = 2'd1,
        PRESS_LONG = 2'd2
    } press_state_t;

    localparam int PARAM_VOLUME  = 0;
    localparam int PARAM_BASS    = 1;
    localparam int PARAM_TREBLE  = 2;
    localparam int PARAM_BALANCE = 3;

endpackage

// File: rtl/encoder_param_ctrl_if.sv
// Bundle between the encoder front-end / parameter consumers and the menu controller.
// master drives the encoder events and reads the menu state; slave is the controller.
interface encoder_param_ctrl_if #(
    parameter int NUM_PARAMS  = 4,
    parameter int VALUE_WIDTH = 8
);
    localparam int SEL_W = $clog2(NUM_PARAMS);

    logic                              enc_state_change_stb;
    logic                              clockwise;
    logic                              click;
    logic                              switch;
    logic [SEL_W-1:0]                  sel_param;
    logic [NUM_PARAMS*VALUE_WIDTH-1:0] param_values;
    logic                              param_update_stb;
    logic [SEL_W-1:0]                  update_index;
    logic                              sel_change_stb;
    logic                              long_press_stb;
    logic                              sw_pressed;

    modport master (
        output enc_state_change_stb, clockwise, click, switch,
        input  sel_param, param_values, param_update_stb, update_index,
               sel_change_stb, long_press_stb, sw_pressed
    );

    modport slave (
        input  enc_state_change_stb, clockwise, click, switch,
        output sel_param, param_values, param_update_stb, update_index,
               sel_change_stb, long_press_stb, sw_pressed
    );

endinterface

// File: rtl/param_stepper.sv
// Per-detent step calculator: tracks time and direction since the last accepted step
// to pick a normal or accelerated delta, and returns the clamped next value.
module param_stepper #(
    parameter int VALUE_WIDTH         = 8,
    parameter int MAX_VALUE           = 255,
    parameter int ACCEL_WINDOW_CYCLES = 5000000,
    parameter int ACCEL_STEP          = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step_en,
    input  logic                   dir_cw,
    input  logic [VALUE_WIDTH-1:0] cur_value,
    output logic [VALUE_WIDTH-1:0] next_value,
    output logic                   changed
);
    localparam int CNT_W = $clog2(ACCEL_WINDOW_CYCLES + 1);
    localparam int W1    = VALUE_WIDTH + 1;

    logic [CNT_W-1:0] accel_cnt_q, accel_cnt_d;
    logic             last_dir_q, last_dir_d;
    logic             accel;
    logic [W1-1:0]    delta;
    logic [W1-1:0]    wide_value;
    logic [W1-1:0]    sum;
    logic [W1-1:0]    clamped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Start saturated so the first detent after reset is never accelerated.
            accel_cnt_q <= CNT_W'(ACCEL_WINDOW_CYCLES);
            last_dir_q  <= 1'b1;
        end else begin
            accel_cnt_q <= accel_cnt_d;
            last_dir_q  <= last_dir_d;
        end
    end

    always_comb begin
        accel      = (accel_cnt_q < CNT_W'(ACCEL_WINDOW_CYCLES)) && (dir_cw == last_dir_q);
        delta      = accel ? W1'(ACCEL_STEP) : W1'(1);
        wide_value = {1'b0, cur_value};
        sum        = wide_value + delta;
        clamped    = wide_value;
        if (dir_cw) begin
            clamped = (sum > W1'(MAX_VALUE)) ? W1'(MAX_VALUE) : sum;
        end else begin
            clamped = (wide_value < delta) ? '0 : (wide_value - delta);
        end
        next_value = clamped[VALUE_WIDTH-1:0];
        changed    = (next_value != cur_value);

        accel_cnt_d = accel_cnt_q;
        last_dir_d  = last_dir_q;
        if (step_en) begin
            accel_cnt_d = '0;
            last_dir_d  = dir_cw;
        end else if (accel_cnt_q < CNT_W'(ACCEL_WINDOW_CYCLES)) begin
            accel_cnt_d = accel_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder parameter menu: detents step the selected value, a short press
// advances the selection and a long press restores the selected value's default.
module encoder_param_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int NUM_PARAMS          = 4,
    parameter int VALUE_WIDTH         = 8,
    parameter int MAX_VALUE           = 255,
    parameter int DEFAULT_VALUE       = 128,
    parameter int ACCEL_WINDOW_CYCLES = 5000000,
    parameter int ACCEL_STEP          = 4,
    parameter int LONG_PRESS_CYCLES   = 50000000,
    parameter int SW_ACTIVE_LOW       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    encoder_param_ctrl_if.slave  bus
);
    localparam int SEL_W  = $clog2(NUM_PARAMS);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    typedef logic [VALUE_WIDTH-1:0] value_t;

    press_state_t      state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  update_index_q, update_index_d;
    value_t            value_q [NUM_PARAMS];
    value_t            value_d [NUM_PARAMS];
    logic              click_dly_q, click_dly_d;
    logic              sw_dly_q, sw_dly_d;
    logic              param_update_stb_q, param_update_stb_d;
    logic              sel_change_stb_q, sel_change_stb_d;
    logic              long_press_stb_q, long_press_stb_d;

    logic              sw_norm;
    logic              step_evt;
    logic              step_accept;
    logic              step_changed;
    value_t            step_value;
    logic              unused_enc_stb;

    // The click rising edge alone defines a step; the event strobe carries no extra information.
    assign unused_enc_stb = bus.enc_state_change_stb;

    assign sw_norm     = (SW_ACTIVE_LOW != 0) ? ~bus.switch : bus.switch;
    assign step_evt    = bus.click & ~click_dly_q;
    assign step_accept = step_evt && (state_q == PRESS_IDLE);

    param_stepper #(
        .VALUE_WIDTH         (VALUE_WIDTH),
        .MAX_VALUE           (MAX_VALUE),
        .ACCEL_WINDOW_CYCLES (ACCEL_WINDOW_CYCLES),
        .ACCEL_STEP          (ACCEL_STEP)
    ) u_stepper (
        .clk        (clk),
        .reset      (reset),
        .step_en    (step_accept),
        .dir_cw     (bus.clockwise),
        .cur_value  (value_q[sel_q]),
        .next_value (step_value),
        .changed    (step_changed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= PRESS_IDLE;
            hold_cnt_q         <= '0;
            sel_q              <= '0;
            update_index_q     <= '0;
            click_dly_q        <= 1'b1;
            sw_dly_q           <= 1'b0;
            param_update_stb_q <= 1'b0;
            sel_change_stb_q   <= 1'b0;
            long_press_stb_q   <= 1'b0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                value_q[i] <= value_t'(DEFAULT_VALUE);
            end
        end else begin
            state_q            <= state_d;
            hold_cnt_q         <= hold_cnt_d;
            sel_q              <= sel_d;
            update_index_q     <= update_index_d;
            click_dly_q        <= click_dly_d;
            sw_dly_q           <= sw_dly_d;
            param_update_stb_q <= param_update_stb_d;
            sel_change_stb_q   <= sel_change_stb_d;
            long_press_stb_q   <= long_press_stb_d;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                value_q[i] <= value_d[i];
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        hold_cnt_d         = hold_cnt_q;
        sel_d              = sel_q;
        update_index_d     = update_index_q;
        click_dly_d        = bus.click;
        sw_dly_d           = sw_norm;
        param_update_stb_d = 1'b0;
        sel_change_stb_d   = 1'b0;
        long_press_stb_d   = 1'b0;
        value_d            = value_q;

        // A step only lands while idle, so it always targets the selection it was made on.
        if (step_accept && step_changed) begin
            value_d[sel_q]     = step_value;
            param_update_stb_d = 1'b1;
            update_index_d     = sel_q;
        end

        case (state_q)
            PRESS_IDLE: begin
                if (sw_norm && !sw_dly_q) begin
                    state_d    = PRESS_HELD;
                    hold_cnt_d = '0;
                end
            end
            PRESS_HELD: begin
                if (!sw_norm) begin
                    sel_d            = (sel_q == SEL_W'(NUM_PARAMS - 1)) ? '0 : sel_q + 1'b1;
                    sel_change_stb_d = 1'b1;
                    state_d          = PRESS_IDLE;
                end else if (hold_cnt_q == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
                    value_d[sel_q]     = value_t'(DEFAULT_VALUE);
                    long_press_stb_d   = 1'b1;
                    param_update_stb_d = 1'b1;
                    update_index_d     = sel_q;
                    state_d            = PRESS_LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            PRESS_LONG: begin
                if (!sw_norm) begin
                    state_d = PRESS_IDLE;
                end
            end
            default: begin
                state_d = PRESS_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_values
        assign bus.param_values[gi*VALUE_WIDTH +: VALUE_WIDTH] = value_q[gi];
    end

    assign bus.sel_param        = sel_q;
    assign bus.param_update_stb = param_update_stb_q;
    assign bus.update_index     = update_index_q;
    assign bus.sel_change_stb   = sel_change_stb_q;
    assign bus.long_press_stb   = long_press_stb_q;
    assign bus.sw_pressed       = sw_dly_q;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Directed scoreboard bench for encoder_param_ctrl: expected strobes are queued when
// stimulus is driven and matched (index, value, cycle) when the DUT strobes.
module tb_encoder_param_ctrl;
    localparam int NP    = 4;
    localparam int VW    = 8;
    localparam int MAXV  = 255;
    localparam int DEF   = 128;
    localparam int WIN   = 20;
    localparam int STEP  = 4;
    localparam int LONG  = 100;

    typedef struct { int idx; int val; int cyc; } upd_t;
    typedef struct { int sel; int cyc; } sel_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    upd_t upd_q[$];
    sel_t sel_q[$];
    int   long_q[$];

    // Reference model state
    int   mval[NP];
    int   msel;
    bit   busy;
    bit   have_last;
    int   last_ev;
    bit   last_cw;

    encoder_param_ctrl_if #(.NUM_PARAMS(NP), .VALUE_WIDTH(VW)) bus ();

    encoder_param_ctrl #(
        .NUM_PARAMS(NP), .VALUE_WIDTH(VW), .MAX_VALUE(MAXV), .DEFAULT_VALUE(DEF),
        .ACCEL_WINDOW_CYCLES(WIN), .ACCEL_STEP(STEP), .LONG_PRESS_CYCLES(LONG),
        .SW_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pval(input int i);
        return 32'(bus.param_values[i*VW +: VW]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) mval[i] = DEF;
        msel = 0;
        have_last = 1'b0;
        last_ev = 0;
        last_cw = 1'b0;
    endtask

    // One detent: click drops for `lead` cycles, then rises with the given direction.
    task automatic detent(input bit cw, input int lead);
        int ev, old_v, new_v, delta;
        bus.click = 1'b0;
        bus.enc_state_change_stb = 1'b1;
        tick();
        bus.enc_state_change_stb = 1'b0;
        repeat (lead - 1) tick();
        bus.clockwise = cw;
        bus.click = 1'b1;
        bus.enc_state_change_stb = 1'b1;
        ev = cyc + 1;
        if (!busy) begin
            delta = (have_last && (ev - last_ev - 1) < WIN && cw == last_cw) ? STEP : 1;
            old_v = mval[msel];
            new_v = cw ? old_v + delta : old_v - delta;
            if (new_v > MAXV) new_v = MAXV;
            if (new_v < 0) new_v = 0;
            if (new_v != old_v) upd_q.push_back('{idx: msel, val: new_v, cyc: ev});
            mval[msel] = new_v;
            have_last = 1'b1;
            last_ev = ev;
            last_cw = cw;
        end
        tick();
        bus.enc_state_change_stb = 1'b0;
    endtask

    task automatic move_to(input int target);
        int diff;
        for (int guard = 0; guard < 400 && mval[msel] != target; guard++) begin
            diff = target - mval[msel];
            detent(diff > 0, (diff >= STEP || diff <= -STEP) ? 5 : 30);
        end
        repeat (2) tick();
        check("move_to", pval(msel), 32'(target));
    endtask

    // Hold the switch down for `hold` cycles, then release.
    task automatic press(input int hold);
        int pcyc;
        bus.switch = 1'b0;
        busy = 1'b1;
        pcyc = cyc + 1;
        if (hold >= LONG + 1) begin
            long_q.push_back(pcyc + LONG);
            upd_q.push_back('{idx: msel, val: DEF, cyc: pcyc + LONG});
            mval[msel] = DEF;
        end
        repeat (hold) tick();
        bus.switch = 1'b1;
        if (hold < LONG + 1) begin
            msel = (msel + 1) % NP;
            sel_q.push_back('{sel: msel, cyc: cyc + 1});
        end
        tick();
        busy = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every strobe must match the head of its queue.
    always @(posedge clk) begin
        upd_t u;
        sel_t s;
        int   l;
        #1;
        if (bus.param_update_stb === 1'b1) begin
            n_assert++;
            assert (upd_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_update observed=idx%0d expected=none cyc=%0d", bus.update_index, cyc);
            end
            if (upd_q.size() > 0) begin
                u = upd_q.pop_front();
                check("update_index", 32'(bus.update_index), 32'(u.idx));
                check("update_value", pval(u.idx), 32'(u.val));
                check("update_cycle", 32'(cyc), 32'(u.cyc));
            end
        end
        if (bus.sel_change_stb === 1'b1) begin
            n_assert++;
            assert (sel_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_sel_change observed=%0d expected=none", bus.sel_param);
            end
            if (sel_q.size() > 0) begin
                s = sel_q.pop_front();
                check("sel_value", 32'(bus.sel_param), 32'(s.sel));
                check("sel_cycle", 32'(cyc), 32'(s.cyc));
            end
        end
        if (bus.long_press_stb === 1'b1) begin
            n_assert++;
            assert (long_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_long_press observed=1 expected=0 cyc=%0d", cyc);
            end
            if (long_q.size() > 0) begin
                l = long_q.pop_front();
                check("long_cycle", 32'(cyc), 32'(l));
            end
        end
    end

    initial begin
        bus.enc_state_change_stb = 1'b0;
        bus.clockwise = 1'b0;
        bus.click = 1'b1;
        bus.switch = 1'b1;
        busy = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_sel", 32'(bus.sel_param), 32'd0);
        check("rst_val0", pval(0), 32'(DEF));
        check("rst_val3", pval(3), 32'(DEF));
        check("rst_upd_idx", 32'(bus.update_index), 32'd0);
        check("rst_sw_pressed", 32'(bus.sw_pressed), 32'd0);
        check("rst_strobes", 32'({bus.param_update_stb, bus.sel_change_stb, bus.long_press_stb}), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("no_step_at_reset", pval(0), 32'(DEF));

        // Three slow clockwise detents
        for (int i = 0; i < 3; i++) detent(1'b1, 49);
        tick();
        check("slow_cw_131", pval(0), 32'd131);

        // Accelerated run, then a reversal
        move_to(DEF);
        repeat (30) tick();
        for (int i = 0; i < 3; i++) detent(1'b1, 9);
        tick();
        check("fast_cw_137", pval(0), 32'd137);
        detent(1'b0, 9);
        tick();
        check("reverse_136", pval(0), 32'd136);

        // Upper clamp
        move_to(254);
        detent(1'b1, 5);
        detent(1'b1, 5);
        repeat (3) tick();
        check("clamp_high", pval(0), 32'd255);

        // Lower clamp
        move_to(1);
        detent(1'b0, 5);
        detent(1'b0, 5);
        repeat (3) tick();
        check("clamp_low", pval(0), 32'd0);

        // Short presses walk the selection round
        for (int i = 1; i <= NP; i++) begin
            press(30);
            check("sel_walk", 32'(bus.sel_param), 32'(i % NP));
        end
        check("sw_released", 32'(bus.sw_pressed), 32'd0);

        // Long press restores the selected parameter
        press(30);
        press(30);
        move_to(200);
        press(150);
        repeat (3) tick();
        check("long_restore", pval(2), 32'(DEF));
        check("long_keeps_sel", 32'(bus.sel_param), 32'd2);

        // Detent while held is ignored; then async reset mid-hold
        bus.switch = 1'b0;
        busy = 1'b1;
        repeat (5) tick();
        check("sw_pressed_held", 32'(bus.sw_pressed), 32'd1);
        detent(1'b1, 3);
        repeat (3) tick();
        check("held_detent_ignored", pval(2), 32'(DEF));
        move_to_dummy_guard: begin end
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_sel", 32'(bus.sel_param), 32'd0);
        check("async_rst_val2", pval(2), 32'(DEF));
        check("async_rst_strobes", 32'({bus.param_update_stb, bus.sel_change_stb, bus.long_press_stb}), 32'd0);
        bus.switch = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();
        busy = 1'b0;
        repeat (20) tick();
        check("post_rst_sel", 32'(bus.sel_param), 32'd0);

        // Every queued expectation must have been consumed
        check("upd_q_empty", 32'(upd_q.size()), 32'd0);
        check("sel_q_empty", 32'(sel_q.size()), 32'd0);
        check("long_q_empty", 32'(long_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_param_ctrl.md
Name: encoder_param_ctrl

Overview:
- Consumes the debounced rotary-encoder event outputs (enc_state_change_stb, clockwise, click, switch) and turns them into a user-parameter menu for the audio path, e.g. volume, bass, treble and balance.
- Holds NUM_PARAMS saturating value registers. Steps the selected one per detent, with acceleration on fast spins.
- A short switch press advances the selection. A long press restores the selected parameter's default.
- Sits between the encoder front-end and the DSP coefficient/CPU register block.

Parameters:
- NUM_PARAMS, 4, number of menu parameters (2..8).
- VALUE_WIDTH, 8, width of each parameter value.
- MAX_VALUE, 255, upper clamp for every value (lower clamp is 0).
- DEFAULT_VALUE, 128, reset and long-press restore value.
- ACCEL_WINDOW_CYCLES, 5000000, a same-direction detent within this many clocks of the previous one is accelerated.
- ACCEL_STEP, 4, step size when accelerated (normal step is 1).
- LONG_PRESS_CYCLES, 50000000, hold time that qualifies a long press.
- SW_ACTIVE_LOW, 1, 1 means switch==0 is "pressed".

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enc_state_change_stb  in  1  encoder event strobe (qualifier only; see Behaviour).
- clockwise  in  1  rotation direction, valid when click rises.
- click  in  1  high while the encoder sits at a detent.
- switch  in  1  debounced push-switch level.
- sel_param  out  $clog2(NUM_PARAMS)  currently selected parameter index.
- param_values  out  NUM_PARAMS*VALUE_WIDTH  flattened values; param i is at [i*VALUE_WIDTH +: VALUE_WIDTH].
- param_update_stb  out  1  one-cycle pulse when any value changes or is restored.
- update_index  out  $clog2(NUM_PARAMS)  index written on the param_update_stb cycle.
- sel_change_stb  out  1  one-cycle pulse when sel_param advances.
- long_press_stb  out  1  one-cycle pulse when a long press qualifies.
- sw_pressed  out  1  registered, polarity-normalised switch state.

Behaviour:
- Reset (reset==0, asynchronous):
  - all values = DEFAULT_VALUE; sel_param = 0;
  - all strobes 0; update_index = 0; sw_pressed = 0;
  - FSM = IDLE; accel counter saturated (next step is not accelerated);
  - click_dly = 1, so a detent already present at reset does not produce a step.
- Input registration: click_dly and sw_dly register click and the normalised switch every cycle.
- Step event:
  - condition: click==1 && click_dly==0; direction = clockwise on that cycle.
  - enc_state_change_stb is not required beyond this edge.
- Step latency: the value register and param_update_stb update on the clock edge after the step-event cycle, i.e. 1 cycle latency. update_index = sel_param at the step-event cycle.
- Step size:
  - delta = ACCEL_STEP if accel_cnt < ACCEL_WINDOW_CYCLES and the direction equals the last step direction; otherwise delta = 1.
  - accel_cnt clears to 0 on every step and otherwise increments, saturating at ACCEL_WINDOW_CYCLES.
- Arithmetic:
  - compute in VALUE_WIDTH+1 bits; clockwise adds delta, counter-clockwise subtracts it;
  - clamp to [0, MAX_VALUE];
  - if the clamped result equals the old value (already at the limit), no param_update_stb is issued.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE: a rising edge of sw_pressed → PRESSED, hold_cnt = 0.
  - PRESSED: hold_cnt increments each cycle.
    - release before hold_cnt reaches LONG_PRESS_CYCLES-1: short press → sel_param = (sel_param+1) mod NUM_PARAMS, pulse sel_change_stb, → IDLE.
    - hold_cnt reaches LONG_PRESS_CYCLES-1: value[sel_param] = DEFAULT_VALUE, pulse long_press_stb and param_update_stb (always issued, even if the value was already default), → LONG_HELD.
  - LONG_HELD: release → IDLE with no selection change.
- Step events while in PRESSED or LONG_HELD are ignored: no value change and accel_cnt is not cleared.
- Step and press rising edge on the same cycle: the step applies first, to the current sel_param, then the FSM enters PRESSED.
- Release and step on the same cycle in PRESSED: the step is ignored; the selection advances.
- Wrap-around: sel_param wraps from NUM_PARAMS-1 to 0, including non-power-of-two NUM_PARAMS.
- Strobes are never asserted for more than one consecutive cycle per event.

Decomposition:
- Shared package audio_ctrl_pkg holds:
  - typedef enum for the FSM (PRESS_IDLE, PRESS_HELD, PRESS_LONG);
  - localparam indices PARAM_VOLUME=0, PARAM_BASS=1, PARAM_TREBLE=2, PARAM_BALANCE=3.
- One sub-module, param_stepper: combinational-plus-register unit holding the accel counter and last direction. It outputs the clamped next value and a changed flag for a given current value and direction.
- The press FSM and value array stay in the top.

Test Plan (run with LONG_PRESS_CYCLES=100, ACCEL_WINDOW_CYCLES=20, ACCEL_STEP=4, SW_ACTIVE_LOW=1):
- Reset release, then 3 clockwise detents spaced 50 cycles apart → param 0 = 131; 3 update pulses, each 1 cycle after its click rise; update_index = 0.
- 3 clockwise detents spaced 10 cycles apart from 128 → 129, 133, 137. Then one counter-clockwise detent within 10 cycles → 136 (direction change, no acceleration).
- Param at 254, 2 fast clockwise detents → 255, then no strobe (clamped). Param at 1, fast counter-clockwise detents → 0, then no strobe.
- switch low for 30 cycles, 4 times → sel_param 1, 2, 3, 0; four sel_change_stb pulses, no long_press_stb.
- sel=2, value 200, switch low for 150 cycles → long_press_stb at cycle 100 of the hold; param 2 = 128; sel_param stays 2 after release.
- Detent while switch held → value unchanged. Async reset asserted mid-hold → all values 128, sel 0, FSM IDLE immediately, no strobe after release.
